// File: rtl/shift_chain_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shift_chain_seq_if                                         |
// | Purpose : Bundles the control, serial-input and parallel-output      |
// |           handshake signals of the shift-chain sequencer.            |
// | Ports   : start, abort        frame control (master -> sequencer)    |
// |           din, din_valid      serial bit + valid (master -> seq)     |
// |           din_ready           sequencer takes din (seq -> master)    |
// |           dout, dout_valid    parallel word + valid (seq -> master)  |
// |           dout_ready          consumer takes dout (master -> seq)    |
// |           busy, bit_cnt       status (seq -> master)                 |
// | Modports: master = bit source / word consumer, slave = sequencer     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface shift_chain_seq_if #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 2
);
   logic             start;
   logic             abort;
   logic             din;
   logic             din_valid;
   logic             din_ready;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             busy;
   logic [CNT_W-1:0] bit_cnt;

   modport master (
      output start, abort, din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid, busy, bit_cnt
   );

   modport slave (
      input  start, abort, din, din_valid, dout_ready,
      output din_ready, dout, dout_valid, busy, bit_cnt
   );
endinterface
`default_nettype wire

// File: rtl/shift_chain_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : shift_chain_seq                                            |
// | Purpose : Frames a WIDTH-bit serial capture into a shift chain and   |
// |           presents the filled chain as a parallel word.              |
// | Ports   : clk    rising-edge clock                                   |
// |           rst_n  asynchronous active-low reset                       |
// |           bus    shift_chain_seq_if.slave (handshakes and status)    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module shift_chain_seq #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 2
) (
   input  wire              clk,
   input  wire              rst_n,
   shift_chain_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] chain;
   logic [WIDTH-1:0] chain_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             accept;

   // din_ready is a function of state only so the source never sees a
   // combinational path from its own valid back to ready.
   assign accept = bus.din_valid & (state == SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         chain <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         chain <= chain_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      chain_nxt = chain;
      cnt_nxt   = cnt;

      if (bus.abort) begin
         state_nxt = IDLE;
         chain_nxt = '0;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state_nxt = SHIFT;
                  chain_nxt = '0;
                  cnt_nxt   = '0;
               end
            end
            SHIFT: begin
               if (accept) begin
                  // Newest bit enters stage0; the oldest migrates upward.
                  chain_nxt = {chain[WIDTH-2:0], bus.din};
                  if (cnt == LAST_CNT) begin
                     state_nxt = FULL;
                     cnt_nxt   = FULL_CNT;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
            end
            FULL: begin
               // Chain is frozen until the consumer takes the word. Taking
               // the word with start pending opens the next frame directly.
               if (bus.dout_ready) begin
                  cnt_nxt = '0;
                  if (bus.start) begin
                     state_nxt = SHIFT;
                     chain_nxt = '0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               chain_nxt = '0;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign bus.din_ready  = (state == SHIFT);
   assign bus.dout_valid = (state == FULL);
   assign bus.busy       = (state != IDLE);
   assign bus.dout       = chain;
   assign bus.bit_cnt    = cnt;

endmodule
`default_nettype wire

// File: tb/tb_shift_chain_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_shift_chain_seq                                         |
// | Purpose : Directed self-checking bench for shift_chain_seq with a    |
// |           queue of expected frame words.                             |
// | Ports   : none                                                       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_shift_chain_seq;

   localparam int WIDTH = 3;
   localparam int CNT_W = 2;

   logic clk;
   logic rst_n;

   shift_chain_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   shift_chain_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] sb[$];
   logic [WIDTH-1:0] model_word;
   int               model_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change at negedge; outputs are sampled at the following negedge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic st, input logic ab, input logic d,
                        input logic dv, input logic dr);
      bus.start      = st;
      bus.abort      = ab;
      bus.din        = d;
      bus.din_valid  = dv;
      bus.dout_ready = dr;
   endtask

   task automatic begin_frame();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      model_word = '0;
      model_cnt  = 0;
      check("start_busy", 32'(bus.busy), 32'd1);
      check("start_ready", 32'(bus.din_ready), 32'd1);
      check("start_cnt", 32'(bus.bit_cnt), 32'd0);
   endtask

   // One SHIFT-state cycle; the model shifts only when the bit is valid.
   task automatic send_bit(input logic d, input logic dv, input logic st);
      drive(st, 1'b0, d, dv, 1'b0);
      tick();
      if (dv) begin
         model_word = {model_word[WIDTH-2:0], d};
         model_cnt++;
         if (model_cnt == WIDTH) sb.push_back(model_word);
      end
      check("bit_cnt", 32'(bus.bit_cnt), 32'(model_cnt));
   endtask

   task automatic expect_frame();
      logic [WIDTH-1:0] exp_word;
      int               waited;
      waited = 0;
      while (!bus.dout_valid && waited < 8) begin
         tick();
         waited++;
      end
      if (!bus.dout_valid) begin
         check("frame_timeout", 32'(bus.dout_valid), 32'd1);
      end else if (sb.size() == 0) begin
         check("sb_empty", 32'(sb.size()), 32'd1);
      end else begin
         exp_word = sb.pop_front();
         check("frame_dout", 32'(bus.dout), 32'(exp_word));
         check("full_ready", 32'(bus.din_ready), 32'd0);
         check("full_cnt", 32'(bus.bit_cnt), 32'(WIDTH));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_word = '0;
      model_cnt  = 0;
      @(negedge clk);
      check("rst_dout", 32'(bus.dout), 32'd0);
      check("rst_valid", 32'(bus.dout_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ready", 32'(bus.din_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_busy", 32'(bus.busy), 32'd0);

      // Frame 1,0,1 with valid every cycle; consume without start.
      begin_frame();
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0);
      check("pre_full_valid", 32'(bus.dout_valid), 32'd0);
      send_bit(1'b1, 1'b1, 1'b0);
      check("latency_valid", 32'(bus.dout_valid), 32'd1);
      expect_frame();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("take_idle_busy", 32'(bus.busy), 32'd0);
      check("take_valid", 32'(bus.dout_valid), 32'd0);
      check("take_cnt", 32'(bus.bit_cnt), 32'd0);
      check("take_retain", 32'(bus.dout), 32'b101);

      // Gaps in din_valid: the garbage bits must not shift in.
      begin_frame();
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0);
      expect_frame();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();

      // Backpressure in FULL, then back-to-back frame.
      begin_frame();
      send_bit(1'b0, 1'b1, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0);
      expect_frame();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
         tick();
         check("hold_dout", 32'(bus.dout), 32'b011);
         check("hold_valid", 32'(bus.dout_valid), 32'd1);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_ready", 32'(bus.din_ready), 32'd1);
      check("b2b_valid", 32'(bus.dout_valid), 32'd0);
      check("b2b_dout", 32'(bus.dout), 32'd0);
      check("b2b_cnt", 32'(bus.bit_cnt), 32'd0);
      model_word = '0;
      model_cnt  = 0;

      // Abort after two bits, overriding a concurrent accept.
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_cnt", 32'(bus.bit_cnt), 32'd0);
      check("abort_dout", 32'(bus.dout), 32'd0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         tick();
         check("idle_dv_dout", 32'(bus.dout), 32'd0);
         check("idle_dv_cnt", 32'(bus.bit_cnt), 32'd0);
         check("idle_dv_busy", 32'(bus.busy), 32'd0);
      end

      // start in SHIFT and in FULL without dout_ready is ignored.
      begin_frame();
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b1, 1'b1);
      send_bit(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         tick();
         check("full_start_valid", 32'(bus.dout_valid), 32'd1);
      end
      expect_frame();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      check("end_idle", 32'(bus.busy), 32'd0);

      // Asynchronous reset mid-SHIFT with two bits accepted.
      begin_frame();
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b1, 1'b0);
      check("pre_rst_dout", 32'(bus.dout), 32'b010);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_dout", 32'(bus.dout), 32'd0);
      check("arst_valid", 32'(bus.dout_valid), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_cnt", 32'(bus.bit_cnt), 32'd0);
      check("arst_ready", 32'(bus.din_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
